// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage and imem.
// One request outstanding at a time; rvalid pulses once per accepted request.
interface fetch_stage_if;
  localparam int unsigned XLEN = 32;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_ready;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage with IF/ID register: single-outstanding imem
// fetch, one-entry hold buffer for stalled responses, redirect squashing.
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 StallF,
  input  logic                 StallD,
  input  logic                 FlushD,
  input  logic                 PCSrcE,
  input  logic [31:0]          PCTargetE,
  fetch_stage_if.master        imem,
  output logic [31:0]          InstrD,
  output logic [31:0]          PCD,
  output logic [31:0]          PCPlus4D,
  output logic                 ValidD
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pcf_q, pcf_d;
  logic [XLEN-1:0] hold_instr_q, hold_pc_q;
  logic [XLEN-1:0] ifid_instr_q, ifid_pc_q, ifid_pc4_q;
  logic            ifid_valid_q;

  logic            stall_c;
  logic            imem_req_c;
  logic            deliver_c;
  logic            capture_c;
  logic [XLEN-1:0] dlv_instr_c;
  logic [XLEN-1:0] dlv_pc_c;

  assign stall_c = StallF | StallD;

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_REQ;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (imem.imem_ready) state_d = PCSrcE ? S_DROP : S_WAIT;
      end
      S_WAIT: begin
        if (imem.imem_rvalid) begin
          if (PCSrcE || !stall_c) state_d = S_REQ;
          else                    state_d = S_HOLD;
        end else if (PCSrcE) begin
          state_d = S_DROP;
        end
      end
      S_HOLD: begin
        if (PCSrcE || !stall_c) state_d = S_REQ;
      end
      S_DROP: begin
        if (imem.imem_rvalid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Output/control decode; imem_req depends only on state and reset
  always_comb begin
    imem_req_c  = 1'b0;
    deliver_c   = 1'b0;
    capture_c   = 1'b0;
    dlv_instr_c = imem.imem_rdata;
    dlv_pc_c    = pcf_q;
    unique case (state_q)
      S_REQ:  imem_req_c = !reset;
      S_WAIT: begin
        if (imem.imem_rvalid && !PCSrcE) begin
          deliver_c = !stall_c;
          capture_c = stall_c;
        end
      end
      S_HOLD: begin
        if (!PCSrcE && !stall_c) begin
          deliver_c   = 1'b1;
          dlv_instr_c = hold_instr_q;
          dlv_pc_c    = hold_pc_q;
        end
      end
      default: ;
    endcase
  end

  // Redirect overrides both the sequential increment and StallF
  always_comb begin
    pcf_d = pcf_q;
    if (PCSrcE)         pcf_d = PCTargetE;
    else if (deliver_c) pcf_d = pcf_q + XLEN'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcf_q        <= RESET_PC;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
    end else begin
      pcf_q <= pcf_d;
      if (capture_c) begin
        hold_instr_q <= imem.imem_rdata;
        hold_pc_q    <= pcf_q;
      end
      // IF/ID: flush beats stall; an empty slot becomes a bubble
      if (FlushD || (!StallD && !deliver_c)) begin
        ifid_instr_q <= NOP_INSTR;
        ifid_pc_q    <= '0;
        ifid_pc4_q   <= '0;
        ifid_valid_q <= 1'b0;
      end else if (!StallD) begin
        ifid_instr_q <= dlv_instr_c;
        ifid_pc_q    <= dlv_pc_c;
        ifid_pc4_q   <= dlv_pc_c + XLEN'(4);
        ifid_valid_q <= 1'b1;
      end
    end
  end

  assign imem.imem_req  = imem_req_c;
  assign imem.imem_addr = pcf_q;
  assign InstrD         = ifid_instr_q;
  assign PCD            = ifid_pc_q;
  assign PCPlus4D       = ifid_pc4_q;
  assign ValidD         = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage: variable-latency imem model plus a
// transaction-level reference (outstanding/stale/buffer flags) checked each cycle.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        StallF, StallD, FlushD, PCSrcE;
  logic [31:0] PCTargetE;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  fetch_stage_if imem_bus ();

  fetch_stage #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
    .clk       (clk),
    .reset     (reset),
    .StallF    (StallF),
    .StallD    (StallD),
    .FlushD    (FlushD),
    .PCSrcE    (PCSrcE),
    .PCTargetE (PCTargetE),
    .imem      (imem_bus),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .ValidD    (ValidD)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pcf;
  logic        m_out, m_stale, m_bufv;
  logic [31:0] m_bi, m_bp;
  logic [31:0] e_instr, e_pc, e_pc4;
  logic        e_valid;

  // Memory model state
  logic        mem_busy;
  int          mem_cnt;
  logic [31:0] mem_addr;
  int          lat_cfg;

  // Random knobs (percent)
  int p_stall, p_flush, p_redir, p_ready, p_reset;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pcf = RESET_PC; m_out = 1'b0; m_stale = 1'b0; m_bufv = 1'b0;
    m_bi = '0; m_bp = '0;
    e_instr = NOP_INSTR; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;
  endtask

  // One cycle: drive inputs, check registered/comb outputs, advance model and memory.
  task automatic step(input logic rst, input logic sf, input logic sd, input logic fd,
                      input logic ps, input logic [31:0] tgt, input logic rdy, input logic inj);
    logic        rv, req_exp, dlv;
    logic [31:0] rd, di, dp;
    int          lat;
    rv = (mem_busy && mem_cnt == 0) || inj;
    rd = (mem_busy && mem_cnt == 0) ? memfn(mem_addr) : (inj ? 32'hDEAD_BEEF : $urandom);
    reset = rst; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    imem_bus.imem_ready  = rdy;
    imem_bus.imem_rvalid = rv;
    imem_bus.imem_rdata  = rd;
    #1;
    req_exp = !rst && !m_out && !m_bufv;
    check_eq("imem_req",  32'(imem_bus.imem_req), 32'(req_exp));
    check_eq("imem_addr", imem_bus.imem_addr, m_pcf);
    check_eq("InstrD",    InstrD,   e_instr);
    check_eq("PCD",       PCD,      e_pc);
    check_eq("PCPlus4D",  PCPlus4D, e_pc4);
    check_eq("ValidD",    32'(ValidD), 32'(e_valid));

    if (rst) begin
      model_reset();
    end else begin
      dlv = 1'b0; di = '0; dp = '0;
      if (req_exp) begin
        if (rdy) begin m_out = 1'b1; m_stale = ps; end
      end else if (m_out) begin
        if (rv) begin
          m_out = 1'b0;
          if (!m_stale && !ps) begin
            if (!sf && !sd) begin dlv = 1'b1; di = rd; dp = m_pcf; end
            else begin m_bufv = 1'b1; m_bi = rd; m_bp = m_pcf; end
          end
        end else if (ps) begin
          m_stale = 1'b1;
        end
      end else if (m_bufv) begin
        if (ps) m_bufv = 1'b0;
        else if (!sf && !sd) begin dlv = 1'b1; di = m_bi; dp = m_bp; m_bufv = 1'b0; end
      end
      if (fd) begin
        e_instr = NOP_INSTR; e_pc = '0; e_pc4 = '0; e_valid = 1'b0;
      end else if (!sd) begin
        if (dlv) begin e_instr = di; e_pc = dp; e_pc4 = dp + 32'd4; e_valid = 1'b1; end
        else begin e_instr = NOP_INSTR; e_pc = '0; e_pc4 = '0; e_valid = 1'b0; end
      end
      m_pcf = ps ? tgt : (dlv ? m_pcf + 32'd4 : m_pcf);
    end

    // Memory is reset together with the fetch stage
    if (rst) mem_busy = 1'b0;
    else if (mem_busy && mem_cnt == 0) mem_busy = 1'b0;
    else if (mem_busy) mem_cnt--;
    if (req_exp && rdy) begin
      lat = (lat_cfg == 0) ? int'($urandom_range(1, 4)) : lat_cfg;
      mem_busy = 1'b1; mem_cnt = lat - 1; mem_addr = imem_bus.imem_addr;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic free_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
  endtask

  task automatic rand_step();
    logic [31:0] tgt;
    tgt = $urandom;
    if ($urandom_range(0, 9) != 0) tgt[1:0] = 2'b00;
    if ($urandom_range(0, 19) == 0) tgt = 32'hFFFF_FFFC;
    step($urandom_range(0, 99) < p_reset,
         $urandom_range(0, 99) < p_stall,
         $urandom_range(0, 99) < p_stall,
         $urandom_range(0, 99) < p_flush,
         $urandom_range(0, 99) < p_redir,
         tgt,
         $urandom_range(0, 99) < p_ready,
         1'b0);
  endtask

  task automatic wait_outstanding(input string tag);
    for (int i = 0; i < 20 && !(m_out && !m_stale); i++) free_step();
    check_eq(tag, 32'(m_out && !m_stale), 32'd1);
  endtask

  initial begin
    reset = 1'b1; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    PCTargetE = '0;
    imem_bus.imem_ready = 1'b0; imem_bus.imem_rvalid = 1'b0; imem_bus.imem_rdata = '0;
    mem_busy = 1'b0; mem_cnt = 0; mem_addr = '0; lat_cfg = 1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

    // Unstalled streaming, then a 3-cycle stall landing on the 0x8 response
    for (int i = 0; i < 5; i++) free_step();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) free_step();

    // Redirect while waiting on a slow response
    lat_cfg = 4;
    wait_outstanding("wait_before_redirect");
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_0100, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) free_step();

    // Redirect + flush coinciding with rvalid
    lat_cfg = 1;
    wait_outstanding("wait_before_redirect_rv");
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) free_step();

    // PC wraparound at the top of the address space
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFC, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) free_step();

    // Reset while waiting, stale rvalid arriving right after reset
    lat_cfg = 5;
    wait_outstanding("wait_before_reset");
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    lat_cfg = 1;
    for (int i = 0; i < 6; i++) free_step();

    // Randomized soak
    lat_cfg = 0;
    p_stall = 20; p_flush = 8; p_redir = 8; p_ready = 70; p_reset = 1;
    for (int i = 0; i < 3000; i++) rand_step();
    p_stall = 50; p_flush = 3; p_redir = 3; p_ready = 40; p_reset = 0;
    for (int i = 0; i < 2000; i++) rand_step();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
